// File: rtl/note_player_pkg.sv
// Shared widths and state encoding for the note player and its frequency ROM.
package note_player_pkg;

  localparam int unsigned NOTE_WIDTH     = 6;
  localparam int unsigned DURATION_WIDTH = 6;
  localparam int unsigned STEP_WIDTH     = 20;
  localparam int unsigned NP_SWIDTH      = 2;

  typedef enum logic [NP_SWIDTH-1:0] {
    NP_IDLE    = 2'd0,
    NP_LOAD    = 2'd1,
    NP_PLAYING = 2'd2,
    NP_DONE    = 2'd3
  } np_state_e;

endpackage

// File: rtl/frequency_rom.sv
// Note index to phase-increment ROM, one-cycle synchronous read.
// Step = f * 2^20 / 48000 with note 49 = A4 (440 Hz), equal temperament; entry 0 is a rest.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic                  clk,
  input  logic [NOTE_WIDTH-1:0] addr,
  output logic [STEP_WIDTH-1:0] dout
);

  logic [STEP_WIDTH-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = '0;
    case (addr)
      6'd1:  dout_d = 20'd601;    6'd2:  dout_d = 20'd636;    6'd3:  dout_d = 20'd674;
      6'd4:  dout_d = 20'd714;    6'd5:  dout_d = 20'd757;    6'd6:  dout_d = 20'd802;
      6'd7:  dout_d = 20'd850;    6'd8:  dout_d = 20'd900;    6'd9:  dout_d = 20'd954;
      6'd10: dout_d = 20'd1010;   6'd11: dout_d = 20'd1070;   6'd12: dout_d = 20'd1134;
      6'd13: dout_d = 20'd1201;   6'd14: dout_d = 20'd1273;   6'd15: dout_d = 20'd1349;
      6'd16: dout_d = 20'd1429;   6'd17: dout_d = 20'd1514;   6'd18: dout_d = 20'd1604;
      6'd19: dout_d = 20'd1699;   6'd20: dout_d = 20'd1800;   6'd21: dout_d = 20'd1907;
      6'd22: dout_d = 20'd2021;   6'd23: dout_d = 20'd2141;   6'd24: dout_d = 20'd2268;
      6'd25: dout_d = 20'd2403;   6'd26: dout_d = 20'd2546;   6'd27: dout_d = 20'd2697;
      6'd28: dout_d = 20'd2858;   6'd29: dout_d = 20'd3028;   6'd30: dout_d = 20'd3208;
      6'd31: dout_d = 20'd3398;   6'd32: dout_d = 20'd3600;   6'd33: dout_d = 20'd3815;
      6'd34: dout_d = 20'd4041;   6'd35: dout_d = 20'd4282;   6'd36: dout_d = 20'd4536;
      6'd37: dout_d = 20'd4806;   6'd38: dout_d = 20'd5092;   6'd39: dout_d = 20'd5395;
      6'd40: dout_d = 20'd5715;   6'd41: dout_d = 20'd6055;   6'd42: dout_d = 20'd6415;
      6'd43: dout_d = 20'd6797;   6'd44: dout_d = 20'd7201;   6'd45: dout_d = 20'd7629;
      6'd46: dout_d = 20'd8083;   6'd47: dout_d = 20'd8563;   6'd48: dout_d = 20'd9072;
      6'd49: dout_d = 20'd9612;   6'd50: dout_d = 20'd10184;  6'd51: dout_d = 20'd10789;
      6'd52: dout_d = 20'd11431;  6'd53: dout_d = 20'd12110;  6'd54: dout_d = 20'd12830;
      6'd55: dout_d = 20'd13593;  6'd56: dout_d = 20'd14402;  6'd57: dout_d = 20'd15258;
      6'd58: dout_d = 20'd16165;  6'd59: dout_d = 20'd17127;  6'd60: dout_d = 20'd18145;
      6'd61: dout_d = 20'd19224;  6'd62: dout_d = 20'd20367;  6'd63: dout_d = 20'd21578;
      default: dout_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/note_player.sv
// Note player: latches a note from the song reader, drives its phase step for the
// requested number of beats, then answers with a one-cycle note_done.
module note_player
  import note_player_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      new_note,
  input  logic [NOTE_WIDTH-1:0]     note,
  input  logic [DURATION_WIDTH-1:0] duration,
  input  logic                      beat,
  output logic [STEP_WIDTH-1:0]     step_size,
  output logic                      note_active,
  output logic                      note_done
);

  np_state_e                 state_d, state_q;
  logic [NOTE_WIDTH-1:0]     note_d, note_q;
  logic [DURATION_WIDTH-1:0] remaining_d, remaining_q;
  logic [STEP_WIDTH-1:0]     tone_d, tone_q;
  logic [STEP_WIDTH-1:0]     step_size_d, step_size_q;
  logic                      note_active_d, note_active_q;
  logic                      note_done_d, note_done_q;
  logic [NOTE_WIDTH-1:0]     rom_addr;
  logic [STEP_WIDTH-1:0]     rom_dout;

  // Look up the incoming note on the strobe edge so its step is ready during LOAD.
  assign rom_addr = new_note ? note : note_q;

  frequency_rom u_frequency_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    remaining_d = remaining_q;
    tone_d      = tone_q;
    if (new_note) begin
      note_d      = note;
      remaining_d = duration;
    end
    unique case (state_q)
      NP_IDLE: begin
        if (new_note) state_d = NP_LOAD;
      end
      NP_LOAD: begin
        if (new_note) begin
          state_d = NP_LOAD;
        end else if (remaining_q == '0) begin
          state_d = NP_DONE;
        end else begin
          state_d = NP_PLAYING;
          tone_d  = (note_q == '0) ? '0 : rom_dout;
        end
      end
      NP_PLAYING: begin
        // A strobe preempts the note and swallows any beat in the same cycle.
        if (new_note) begin
          state_d = NP_LOAD;
        end else if (beat && play) begin
          remaining_d = remaining_q - DURATION_WIDTH'(1);
          if (remaining_q == DURATION_WIDTH'(1)) state_d = NP_DONE;
        end
      end
      NP_DONE: begin
        state_d = new_note ? NP_LOAD : NP_IDLE;
      end
    endcase
  end

  always_comb begin
    note_active_d = (state_d == NP_PLAYING);
    note_done_d   = (state_d == NP_DONE);
    step_size_d   = (state_d == NP_PLAYING && play) ? tone_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= NP_IDLE;
      note_q        <= '0;
      remaining_q   <= '0;
      tone_q        <= '0;
      step_size_q   <= '0;
      note_active_q <= 1'b0;
      note_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      note_q        <= note_d;
      remaining_q   <= remaining_d;
      tone_q        <= tone_d;
      step_size_q   <= step_size_d;
      note_active_q <= note_active_d;
      note_done_q   <= note_done_d;
    end
  end

  assign step_size   = step_size_q;
  assign note_active = note_active_q;
  assign note_done   = note_done_q;

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Responder end of the song-reader note handshake.
- Accepts a note and duration on a one-cycle `new_note` strobe and looks up the phase-accumulator step for that note.
- Drives `step_size` to the sample generator for `duration` beats, then returns a one-cycle `note_done` to the song reader.
- Sits between the song reader and the sine/sample reader in the music-player top.

Parameters:
NOTE_WIDTH, 6, width of note index (0 = rest, 1..63 = pitches)
DURATION_WIDTH, 6, width of duration in beats
STEP_WIDTH, 20, width of phase-increment output

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
play  input  1  1 = playing; 0 = pause (freeze beat count, mute output)
new_note  input  1  one-cycle strobe; note/duration valid this cycle
note  input  NOTE_WIDTH  note index from song reader
duration  input  DURATION_WIDTH  note length in beats
beat  input  1  one-cycle tick, 48 per second, from beat generator
step_size  output  STEP_WIDTH  phase increment for sample generator; 0 = silence
note_active  output  1  high while a note (incl. rest) is sounding/counting
note_done  output  1  one-cycle pulse when current note's duration has elapsed

Behaviour:
- Reset (reset==0, async): state IDLE, step_size=0, note_active=0, note_done=0, beat counter=0, latched note=0.
- States: IDLE, LOAD, PLAYING, DONE (2-bit encoding, constants in the shared header).
- IDLE: outputs 0. If new_note=1, latch note and duration, go to LOAD. The play level does not gate acceptance.
- LOAD: 1 cycle. The frequency ROM (synchronous, 1-cycle read) presents the step for the latched note.
  - If latched duration==0: go to DONE, step_size stays 0.
  - Otherwise: go to PLAYING and register `step_size` = ROM output. Rest (note==0) is forced to step 0.
- Latency: new_note at cycle T → step_size valid from T+2 and note_active=1 from T+2.
- PLAYING: note_active=1.
  - step_size = latched step when play=1, and 0 when play=0.
  - On beat & play: remaining ← remaining−1.
  - On beat & play with remaining==1: go to DONE.
  - beat with play=0 is ignored (pause freezes count).
- DONE: note_done=1 for exactly one cycle, step_size=0, note_active=0. Next state IDLE.
- new_note during PLAYING (preempt): abandon the current note with no note_done for it, latch the new note/duration, go to LOAD.
- new_note during LOAD: re-latch and stay in LOAD, so the last strobe wins.
- new_note during DONE: note_done still pulses, the new note is latched, next state LOAD.
- Simultaneous beat and new_note in PLAYING: new_note wins; the beat is discarded.
- Duration arithmetic is unsigned, DURATION_WIDTH bits. Max 63 beats. The counter never underflows because reaching 1 exits to DONE.
- A reset mid-note returns to IDLE immediately; no note_done is generated.
- All outputs are registered; none depend combinationally on inputs.

Decomposition:
- Shared header defines: NOTE_WIDTH, DURATION_WIDTH, STEP_WIDTH, and the state constants NP_IDLE/NP_LOAD/NP_PLAYING/NP_DONE with NP_SWIDTH=2.
- Sub-module `frequency_rom`:
  - clk, addr[NOTE_WIDTH-1:0], dout[STEP_WIDTH-1:0].
  - Synchronous read, 64 entries, entry 0 = 0.
  - Contents are the equal-tempered steps for the 48 kHz sample rate.
- State and counter registers use the codebase's flip-flop cell with asynchronous active-low clear.

Test Plan:
- Basic note:
  - Stimulus: reset release, play=1, new_note with note=10 and duration=3, beat every 16 cycles.
  - Required: step_size = ROM[10] from T+2; note_done pulses one cycle right after the 3rd beat; step_size=0 afterwards.
- Pause:
  - Stimulus: note=20, duration=4; play=0 after beat 2 for 5 beats, then play=1.
  - Required: step_size=0 and the count frozen during pause; note_done only after 2 further beats.
- Rest and zero duration:
  - Stimulus 1: note=0, duration=2. Required: step_size stays 0, note_active=1, note_done after 2 beats.
  - Stimulus 2: note=5, duration=0. Required: note_done at T+2, step_size never nonzero.
- Preempt:
  - Stimulus: new_note (note=7, duration=8), then new_note (note=9, duration=1) after 2 beats, with a beat in the same cycle.
  - Required: no note_done for note 7; step_size=ROM[9] two cycles after the second strobe; note_done after the next beat.
- Async reset mid-note:
  - Stimulus: reset=0 asserted between clock edges while PLAYING.
  - Required: step_size, note_active and note_done go to 0 without a clock edge; after release, IDLE with no spurious note_done.
- Back-to-back handshake:
  - Stimulus: drive new_note in the DONE cycle (song reader fast path) with note=12, duration=1.
  - Required: note_done pulse seen, then step_size=ROM[12] two cycles later.
